// File: rtl/round_arb.sv
// Shared round-half-to-even unit behind a round-robin arbiter.
// One signed fixed-point word is accepted per cycle from the granted requester.
// It is rounded to its integer part, saturating at the positive maximum, and
// returned registered together with the requester id.
module round_arb #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned FW = 4,
  parameter int unsigned IW = $clog2(N),
  parameter int unsigned CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic            out_valid,
  output logic [DW-FW-1:0] out_data,
  output logic [IW-1:0]   out_id,
  output logic            out_sat,
  input  logic            out_ready,
  output logic [CW-1:0]   sat_cnt,
  output logic            busy
);

  localparam int unsigned OW = DW - FW;
  localparam logic [OW-1:0] max_pos  = {1'b0, {(OW-1){1'b1}}};
  localparam logic [IW-1:0] last_idx = IW'(N - 1);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;
  logic [IW-1:0] gidx;
  logic          found;
  logic [N-1:0]  grant;
  logic          free;
  logic          accept;

  logic [DW-1:0] a;
  logic [OW-1:0] intval;
  logic          half;
  logic          tail;
  logic          roundup;
  logic          sat;
  logic [OW-1:0] sum;
  logic [OW-1:0] rdata;

  // The output slot can take a new result if empty or being drained this cycle.
  assign free      = ~out_valid | out_ready;
  assign req_ready = grant & {N{free}};
  assign accept    = found & free;
  assign busy      = out_valid | (|req_valid);

  // Round-robin search: first valid requester starting at ptr, wrapping mod N.
  always_comb begin
    grant = '0;
    gidx  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr) + k) % N);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        gidx  = cand;
      end
    end
    if (found) grant[gidx] = 1'b1;
  end

  // Select the granted requester's word.
  always_comb begin
    a = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) a = req_data[i*DW +: DW];
    end
  end

  // Round half to even. Only the max positive value can overflow when rounding
  // up, and that case is overridden by saturation, so an OW-bit sum suffices.
  always_comb begin
    intval  = a[DW-1:FW];
    half    = a[FW-1];
    tail    = |a[FW-2:0];
    roundup = half & (tail | intval[0]);
    sat     = roundup & (intval == max_pos);
    sum     = intval + OW'(roundup);
    rdata   = sat ? max_pos : sum;
  end

  // Output register and round-robin pointer; hold everything under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_sat   <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= rdata;
      out_id    <= gidx;
      out_sat   <= sat;
      ptr       <= (gidx == last_idx) ? '0 : gidx + IW'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturation event counter, sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= '0;
    end else if (accept && sat && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_round_arb.sv
// Bench for round_arb: directed test-plan cases plus randomized traffic,
// all checked against a behavioural model built on integer arithmetic.
module tb_round_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned FW = 4;
  localparam int unsigned IW = 2;
  localparam int unsigned CW = 16;
  localparam int unsigned OW = DW - FW;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic [IW-1:0]   out_id;
  logic            out_sat;
  logic            out_ready;
  logic [CW-1:0]   sat_cnt;
  logic            busy;

  round_arb #(.N(N), .DW(DW), .FW(FW), .IW(IW), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .sat_cnt   (sat_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  bit m_valid;
  int m_data;
  int m_id;
  bit m_sat;
  int m_cnt;
  int m_ptr;
  bit m_acc;
  int m_gidx;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Round half to even on the real value a / 2^FW, then clamp to the signed range.
  function automatic int round_ref(input logic [DW-1:0] a, output bit sat);
    int sv;
    int fl;
    int rem;
    int r;
    int mx;
    sv  = int'($signed(a));
    fl  = sv >>> FW;
    rem = sv - fl * (1 << FW);
    r   = fl;
    if (rem > (1 << (FW - 1)) || (rem == (1 << (FW - 1)) && (fl % 2 != 0))) r = fl + 1;
    mx  = (1 << (OW - 1)) - 1;
    sat = (r > mx);
    if (sat) r = mx;
    return r & ((1 << OW) - 1);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = 0; m_id = 0; m_sat = 0; m_cnt = 0; m_ptr = 0;
    m_acc = 0; m_gidx = 0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs before the edge,
  // advance the model at the edge, check registered outputs after it.
  task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ordy);
    bit found;
    int g;
    bit free;
    int exp_rdy;
    bit s;
    int r;
    req_valid = v;
    req_data  = d;
    out_ready = ordy;
    #2;
    found = 0;
    g = 0;
    for (int k = 0; k < int'(N); k++) begin
      if (!found && v[(m_ptr + k) % N]) begin
        found = 1;
        g = (m_ptr + k) % N;
      end
    end
    free    = !m_valid || ordy;
    exp_rdy = (found && free) ? (1 << g) : 0;
    chk("req_ready", int'(req_ready), exp_rdy);
    chk("busy", int'(busy), int'(m_valid || (|v)));
    @(posedge clk);
    m_acc  = found && free;
    m_gidx = g;
    if (m_acc) begin
      r = round_ref(d[g*DW +: DW], s);
      m_valid = 1; m_data = r; m_id = g; m_sat = s;
      m_ptr = (g + 1) % N;
      if (s && m_cnt < (1 << CW) - 1) m_cnt++;
    end else if (ordy) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    if (m_valid) begin
      chk("out_data", int'(out_data), m_data);
      chk("out_id", int'(out_id), m_id);
      chk("out_sat", int'(out_sat), int'(m_sat));
    end
    chk("sat_cnt", int'(sat_cnt), m_cnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [DW-1:0] rt_in  [6] = '{8'h28, 8'h38, 8'h29, 8'h27, 8'hD8, 8'hC8};
  int            rt_exp [6] = '{2, 4, 3, 2, 14, 12};

  initial begin
    bit s;
    int r;
    logic [N-1:0]    rv;
    logic [N*DW-1:0] rd;
    logic [OW-1:0]   hold_data;

    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    out_ready = 1'b0;
    model_reset();

    // Pin the model with hand-computed values.
    r = round_ref(8'h28, s); chk("model_28", r, 2);
    r = round_ref(8'hD8, s); chk("model_D8", r, 14);
    r = round_ref(8'h78, s); chk("model_78", r, 7); chk("model_78_sat", int'(s), 1);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_id", int'(out_id), 0);
    chk("rst_out_sat", int'(out_sat), 0);
    chk("rst_sat_cnt", int'(sat_cnt), 0);
    rst = 1'b0;

    // Rounding table on requester 0.
    for (int i = 0; i < 6; i++) begin
      step(4'b0001, {24'h0, rt_in[i]}, 1'b1);
      chk("rt_data", int'(out_data), rt_exp[i]);
      chk("rt_id", int'(out_id), 0);
      chk("rt_sat", int'(out_sat), 0);
    end

    // Saturation.
    step(4'b0001, {24'h0, 8'h7F}, 1'b1);
    chk("sat7F_data", int'(out_data), 7); chk("sat7F_sat", int'(out_sat), 1);
    step(4'b0001, {24'h0, 8'h78}, 1'b1);
    chk("sat78_data", int'(out_data), 7); chk("sat78_sat", int'(out_sat), 1);
    chk("sat_cnt2", int'(sat_cnt), 2);
    step(4'b0001, {24'h0, 8'h70}, 1'b1);
    chk("sat70_data", int'(out_data), 7); chk("sat70_sat", int'(out_sat), 0);
    chk("sat_cnt_still2", int'(sat_cnt), 2);

    // Asynchronous reset between edges while a result is pending.
    #2;
    rst = 1'b1;
    #1;
    chk("amid_out_valid", int'(out_valid), 0);
    chk("amid_out_data", int'(out_data), 0);
    chk("amid_out_id", int'(out_id), 0);
    chk("amid_sat_cnt", int'(sat_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(4'b1100, {8'h10, 8'h20, 8'h30, 8'h40}, 1'b1);
    chk("post_rst_id", int'(out_id), 2);

    // Fairness, all requesters.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(4'b1111, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
      chk("fair_id", int'(out_id), i % 4);
    end

    // Sparse fairness, then requester 3 alone.
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
      chk("sparse_id", int'(out_id), (i % 2 == 0) ? 1 : 3);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'b1000, {8'h40, 8'h30, 8'h20, 8'h10}, 1'b1);
      chk("solo3_id", int'(out_id), 3);
    end

    // Backpressure with a result pending (id 3, data 4).
    hold_data = out_data;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, {8'h48, 8'h38, 8'h28, 8'h18}, 1'b0);
      chk("bp_ready", int'(req_ready), 0);
      chk("bp_id", int'(out_id), 3);
      chk("bp_data", int'(out_data), int'(hold_data));
    end
    step(4'b1111, {8'h48, 8'h38, 8'h28, 8'h18}, 1'b1);
    chk("bp_resume_id", int'(out_id), 0);
    chk("bp_resume_data", int'(out_data), 2);
    step(4'b1111, {8'h48, 8'h38, 8'h28, 8'h18}, 1'b1);
    chk("bp_next_id", int'(out_id), 1);

    // Randomized traffic; a pending request keeps its data until accepted.
    rv = '0;
    rd = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < int'(N); i++) begin
        if (rv[i] && !(m_acc && m_gidx == i)) begin
          if ($urandom_range(0, 4) == 0) rv[i] = 1'b0;
        end else begin
          rv[i] = ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 3) == 0) rd[i*DW +: DW] = 8'h70 + 8'($urandom_range(0, 15));
          else rd[i*DW +: DW] = 8'($urandom);
        end
      end
      step(rv, rd, ($urandom_range(0, 3) != 0));
      if (c == 1500) begin
        #1;
        do_reset();
        rv = '0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
